// File: rtl/wb_dsp_master_engine_if.sv
// Wishbone B3 classic bus bundle for the DSP master port.
// The master modport is used by the engine and the slave modport by whatever answers it.
interface wb_dsp_master_engine_if #(
    parameter int unsigned aw = 32,
    parameter int unsigned dw = 32
);
    logic [aw-1:0] wb_adr_o;
    logic [dw-1:0] wb_dat_o;
    logic [3:0]    wb_sel_o;
    logic          wb_we_o;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic [2:0]    wb_cti_o;
    logic [1:0]    wb_bte_o;
    logic [dw-1:0] wb_dat_i;
    logic          wb_ack_i;
    logic          wb_err_i;
    logic          wb_rty_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );
endinterface

// File: rtl/wb_dsp_master_engine.sv
// Block-transfer Wishbone master: turns one command into cmd_len classic single-word cycles,
// feeding read data to a valid/ready stream and pulling write data from another.
module wb_dsp_master_engine #(
    parameter int unsigned aw        = 32,
    parameter int unsigned dw        = 32,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic          cmd_start,
    input  logic          cmd_we,
    input  logic [aw-1:0] cmd_adr,
    input  logic [15:0]   cmd_len,
    output logic          cmd_busy,
    output logic          cmd_done,
    output logic [1:0]    cmd_status,
    input  logic [dw-1:0] wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic [dw-1:0] rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    wb_dsp_master_engine_if.master wb
);
    localparam int unsigned LW = 16;
    localparam int unsigned TW = 8;
    localparam int unsigned RW = $clog2(MAX_RETRY + 2);

    localparam logic [1:0] ST_OK  = 2'd0;
    localparam logic [1:0] ST_ERR = 2'd1;
    localparam logic [1:0] ST_RTY = 2'd2;
    localparam logic [1:0] ST_TMO = 2'd3;

    typedef enum logic [2:0] {IDLE, LOAD, BUS, GAP, PUSH, DONE} state_t;

    state_t        state_q, state_n;
    logic [aw-1:0] base_q, base_n;
    logic [LW-1:0] len_q, len_n;
    logic [LW-1:0] idx_q, idx_n;
    logic          we_q, we_n;
    logic [RW-1:0] retry_q, retry_n;
    logic [TW-1:0] timer_q, timer_n;

    logic          cyc_q, cyc_n;
    logic [aw-1:0] adr_q, adr_n;
    logic          wbwe_q, wbwe_n;
    logic [dw-1:0] dat_q, dat_n;
    logic          busy_q, busy_n;
    logic          done_q, done_n;
    logic [1:0]    status_q, status_n;
    logic          wr_ready_q, wr_ready_n;
    logic [dw-1:0] rd_data_q, rd_data_n;
    logic          rd_valid_q, rd_valid_n;

    logic          last_word;

    assign last_word = (idx_q == len_q - LW'(1));

    // State and all registered outputs
    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            we_q       <= 1'b0;
            retry_q    <= '0;
            timer_q    <= '0;
            cyc_q      <= 1'b0;
            adr_q      <= '0;
            wbwe_q     <= 1'b0;
            dat_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            status_q   <= '0;
            wr_ready_q <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            base_q     <= base_n;
            len_q      <= len_n;
            idx_q      <= idx_n;
            we_q       <= we_n;
            retry_q    <= retry_n;
            timer_q    <= timer_n;
            cyc_q      <= cyc_n;
            adr_q      <= adr_n;
            wbwe_q     <= wbwe_n;
            dat_q      <= dat_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
            status_q   <= status_n;
            wr_ready_q <= wr_ready_n;
            rd_data_q  <= rd_data_n;
            rd_valid_q <= rd_valid_n;
        end
    end

    // Next state; bus response priority is err > ack > rty > timeout
    always_comb begin
        state_n   = state_q;
        base_n    = base_q;
        len_n     = len_q;
        idx_n     = idx_q;
        we_n      = we_q;
        retry_n   = retry_q;
        timer_n   = timer_q;
        dat_n     = dat_q;
        status_n  = status_q;
        rd_data_n = rd_data_q;

        case (state_q)
            IDLE: begin
                if (cmd_start && !busy_q) begin
                    base_n  = cmd_adr & ~aw'(3);
                    len_n   = cmd_len;
                    we_n    = cmd_we;
                    idx_n   = '0;
                    retry_n = '0;
                    timer_n = '0;
                    if (cmd_len == '0) begin
                        status_n = ST_OK;
                        state_n  = DONE;
                    end else begin
                        state_n = cmd_we ? LOAD : BUS;
                    end
                end
            end
            LOAD: begin
                if (wr_valid && wr_ready_q) begin
                    dat_n   = wr_data;
                    state_n = BUS;
                end
            end
            BUS: begin
                if (wb.wb_err_i) begin
                    status_n = ST_ERR;
                    state_n  = DONE;
                end else if (wb.wb_ack_i) begin
                    retry_n = '0;
                    timer_n = '0;
                    if (!we_q) begin
                        rd_data_n = wb.wb_dat_i;
                        state_n   = PUSH;
                    end else if (last_word) begin
                        status_n = ST_OK;
                        state_n  = DONE;
                    end else begin
                        idx_n   = idx_q + LW'(1);
                        state_n = LOAD;
                    end
                end else if (wb.wb_rty_i) begin
                    timer_n = '0;
                    if ((32'(retry_q) + 32'd1) > MAX_RETRY) begin
                        status_n = ST_RTY;
                        state_n  = DONE;
                    end else begin
                        retry_n = retry_q + RW'(1);
                        state_n = GAP;
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    status_n = ST_TMO;
                    state_n  = DONE;
                end else begin
                    timer_n = timer_q + TW'(1);
                end
            end
            GAP: state_n = BUS;
            PUSH: begin
                if (rd_ready) begin
                    if (last_word) begin
                        status_n = ST_OK;
                        state_n  = DONE;
                    end else begin
                        idx_n   = idx_q + LW'(1);
                        state_n = BUS;
                    end
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Output register inputs derived from where the FSM is heading
    always_comb begin
        cyc_n      = (state_n == BUS);
        adr_n      = cyc_n ? (base_n + (aw'(idx_n) << 2)) : '0;
        wbwe_n     = cyc_n && we_n;
        wr_ready_n = (state_n == LOAD);
        rd_valid_n = (state_n == PUSH);
        busy_n     = (state_n != IDLE) || (state_q == DONE);
        done_n     = (state_q == DONE);
    end

    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = cyc_q;
    assign wb.wb_adr_o = adr_q;
    assign wb.wb_we_o  = wbwe_q;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_sel_o = cyc_q ? 4'hF : 4'h0;
    assign wb.wb_cti_o = 3'b000;
    assign wb.wb_bte_o = 2'b00;

    assign cmd_busy   = busy_q;
    assign cmd_done   = done_q;
    assign cmd_status = status_q;
    assign wr_ready   = wr_ready_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
endmodule
